// File: rtl/conc_stim_player_pkg.sv
// Shared constants and types for the conc_stim_player stimulus sequencer.
package conc_stim_pkg;

  localparam int OP_W_DEF     = 3;
  localparam int DEPTH_DEF    = 16;
  localparam int OBS_BIT      = 2;
  localparam int CONT_EQL_BIT = 1;
  localparam int EQL_BIT      = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PLAY,
    ST_FINISH
  } state_e;

endpackage

// File: rtl/conc_stim_player_if.sv
// Load/control/playback bundle between a stimulus source and conc_stim_player.
interface conc_stim_player_if #(
  parameter int OP_W   = conc_stim_pkg::OP_W_DEF,
  parameter int ADDR_W = 4
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [OP_W-1:0]   wr_data;
  logic [ADDR_W:0]   len;
  logic              loop_en;
  logic              start;
  logic              hold;
  logic              eql;
  logic              cont_eql;
  logic              obs;
  logic              valid;
  logic              busy;
  logic              done;
  logic              wr_err;
  logic [ADDR_W-1:0] pc;

  modport master (
    output wr_en, wr_addr, wr_data, len, loop_en, start, hold,
    input  eql, cont_eql, obs, valid, busy, done, wr_err, pc
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, len, loop_en, start, hold,
    output eql, cont_eql, obs, valid, busy, done, wr_err, pc
  );
endinterface

// File: rtl/conc_stim_player_mem.sv
// Opcode store: DEPTH x OP_W, synchronous write, synchronous enabled read.
module conc_stim_mem
  import conc_stim_pkg::*;
#(
  parameter int OP_W   = OP_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [OP_W-1:0]   wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [OP_W-1:0]   rdata_o
);

  logic [OP_W-1:0] mem_q [DEPTH];
  logic [OP_W-1:0] rdata_q;

  // Contents survive reset on purpose so a program can be replayed after abort.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // The read register doubles as the opcode output stage; it holds while re_i=0.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)   rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/conc_stim_player.sv
// Plays a stored opcode sequence into b06 (eql/cont_eql/obs), one slot per clock.
//   state     | meaning
//   ST_IDLE   | waiting for start; loads accepted; outputs hold last opcode
//   ST_PLAY   | presenting slots; rd_ptr_q = next slot, len_eff_q = end marker
//   ST_FINISH | done pulse cycle, returns to idle
module conc_stim_player
  import conc_stim_pkg::*;
#(
  parameter int OP_W   = OP_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic             clock_i,
  input  logic             reset_n_i,
  conc_stim_player_if.slave bus
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  state_e            state_q, state_d;
  logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   len_eff_q, len_eff_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              valid_q, valid_d;
  logic              done_q, busy_q, wr_err_q;
  logic [ADDR_W:0]   len_sat, slot;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [OP_W-1:0]   rdata;

  assign len_sat = (bus.len > DEPTH_L) ? DEPTH_L : bus.len;

  conc_stim_mem #(.OP_W(OP_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_mem (
    .clk_i   (clock_i),
    .rst_ni  (reset_n_i),
    .we_i    (bus.wr_en && (state_q == ST_IDLE)),
    .waddr_i (bus.wr_addr),
    .wdata_i (bus.wr_data),
    .re_i    (rd_en),
    .raddr_i (rd_addr),
    .rdata_o (rdata)
  );

  always_comb begin
    state_d   = state_q;
    rd_ptr_d  = rd_ptr_q;
    len_eff_d = len_eff_q;
    pc_d      = pc_q;
    valid_d   = 1'b0;
    rd_en     = 1'b0;
    rd_addr   = pc_q;
    slot      = '0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          len_eff_d = len_sat;
          rd_ptr_d  = '0;
          if (len_sat == '0) begin
            state_d = ST_FINISH;
          end else begin
            state_d = ST_PLAY;
            if (!bus.hold) begin
              rd_en    = 1'b1;
              rd_addr  = '0;
              pc_d     = '0;
              valid_d  = 1'b1;
              rd_ptr_d = (ADDR_W+1)'(1);
            end
          end
        end
      end
      ST_PLAY: begin
        if (!bus.hold) begin
          // rd_ptr_q == len_eff_q means the last slot has already been shown.
          if ((rd_ptr_q == len_eff_q) && !bus.loop_en) begin
            state_d = ST_FINISH;
          end else begin
            slot     = (rd_ptr_q == len_eff_q) ? '0 : rd_ptr_q;
            rd_en    = 1'b1;
            rd_addr  = slot[ADDR_W-1:0];
            pc_d     = slot[ADDR_W-1:0];
            valid_d  = 1'b1;
            rd_ptr_d = slot + (ADDR_W+1)'(1);
          end
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= ST_IDLE;
      rd_ptr_q  <= '0;
      len_eff_q <= '0;
      pc_q      <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      wr_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_ptr_q  <= rd_ptr_d;
      len_eff_q <= len_eff_d;
      pc_q      <= pc_d;
      valid_q   <= valid_d;
      done_q    <= (state_d == ST_FINISH);
      busy_q    <= (state_d != ST_IDLE);
      wr_err_q  <= bus.wr_en && (state_q != ST_IDLE);
    end
  end

  assign bus.eql      = rdata[EQL_BIT];
  assign bus.cont_eql = rdata[CONT_EQL_BIT];
  assign bus.obs      = rdata[OBS_BIT];
  assign bus.valid    = valid_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.wr_err   = wr_err_q;
  assign bus.pc       = pc_q;

endmodule

// File: tb/tb_conc_stim_player.sv
// Directed scenario bench for conc_stim_player with hand-computed expectations.
module tb_conc_stim_player;
  import conc_stim_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;

  conc_stim_player_if #(.OP_W(3), .ADDR_W(4)) bus ();

  conc_stim_player #(.OP_W(3), .DEPTH(16), .ADDR_W(4)) dut (
    .clock_i   (clk),
    .reset_n_i (rst_n),
    .bus       (bus.slave)
  );

  always #5 clk = ~clk;

  logic [2:0] op;
  assign op = {bus.obs, bus.cont_eql, bus.eql};

  logic [2:0] prog [4] = '{3'b001, 3'b010, 3'b100, 3'b111};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [3:0] a, input logic [2:0] d);
    bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
    tick();
    bus.wr_en = 1'b0;
  endtask

  task automatic pulse_start(input logic [4:0] l, input logic lp);
    bus.len = l; bus.loop_en = lp; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    n_total++;
    if ({op, bus.pc, bus.valid, bus.busy, bus.done, bus.wr_err} !== 11'b0) begin
      $display("FAIL reset_state: got op=%b pc=%0d v=%b b=%b d=%b e=%b, want all 0",
               op, bus.pc, bus.valid, bus.busy, bus.done, bus.wr_err);
    end else n_pass++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_load_play();
    logic seen;
    for (int i = 0; i < 4; i++) load(4'(i), prog[i]);
    pulse_start(5'd4, 1'b0);
    for (int i = 0; i < 4; i++) begin
      n_total++;
      if ({bus.valid, bus.pc, op} !== {1'b1, 4'(i), prog[i]} || bus.done !== 1'b0) begin
        $display("FAIL play_slot%0d: got v=%b pc=%0d op=%b d=%b, want v=1 pc=%0d op=%b d=0",
                 i, bus.valid, bus.pc, op, bus.done, i, prog[i]);
      end else n_pass++;
      tick();
    end
    n_total++;
    if (bus.done !== 1'b1 || bus.valid !== 1'b0) begin
      $display("FAIL done_at_start5: got done=%b valid=%b, want done=1 valid=0", bus.done, bus.valid);
    end else n_pass++;
    tick();
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (bus.done) seen = 1'b1;
      if (i < 2) tick();
    end
    n_total++;
    if (seen !== 1'b0 || bus.busy !== 1'b0 || op !== 3'b111 || bus.valid !== 1'b0) begin
      $display("FAIL idle_after_run: got done_again=%b busy=%b op=%b valid=%b, want 0 0 111 0",
               seen, bus.busy, op, bus.valid);
    end else n_pass++;
  endtask

  task automatic test_loop_wrap();
    logic seen;
    pulse_start(5'd4, 1'b1);
    for (int i = 0; i < 10; i++) begin
      n_total++;
      if (bus.valid !== 1'b1 || bus.pc !== 4'(i % 4) || op !== prog[i % 4] || bus.done !== 1'b0) begin
        $display("FAIL loop_cycle%0d: got v=%b pc=%0d op=%b d=%b, want v=1 pc=%0d op=%b d=0",
                 i, bus.valid, bus.pc, op, bus.done, i % 4, prog[i % 4]);
      end else n_pass++;
      if (i == 9) bus.loop_en = 1'b0;
      tick();
    end
    n_total++;
    if (bus.pc !== 4'd2 || bus.valid !== 1'b1) begin
      $display("FAIL loop_stop_slot2: got pc=%0d v=%b, want pc=2 v=1", bus.pc, bus.valid);
    end else n_pass++;
    tick(); tick();
    n_total++;
    if (bus.done !== 1'b1) begin
      $display("FAIL loop_stop_done: got done=%b, want 1", bus.done);
    end else n_pass++;
    tick();
    seen = bus.busy;
    n_total++;
    if (seen !== 1'b0) begin
      $display("FAIL loop_stop_idle: got busy=%b, want 0", seen);
    end else n_pass++;
  endtask

  task automatic test_hold();
    logic seen;
    pulse_start(5'd4, 1'b0);
    tick();
    bus.hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_total++;
      if (op !== 3'b010 || bus.pc !== 4'd1 || bus.valid !== 1'b0 || bus.busy !== 1'b1) begin
        $display("FAIL hold_cycle%0d: got op=%b pc=%0d v=%b b=%b, want op=010 pc=1 v=0 b=1",
                 i, op, bus.pc, bus.valid, bus.busy);
      end else n_pass++;
    end
    bus.hold = 1'b0;
    tick();
    n_total++;
    if (op !== 3'b100 || bus.pc !== 4'd2 || bus.valid !== 1'b1) begin
      $display("FAIL hold_resume: got op=%b pc=%0d v=%b, want op=100 pc=2 v=1", op, bus.pc, bus.valid);
    end else n_pass++;
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      tick();
      if (bus.done) seen = 1'b1;
    end
    n_total++;
    if (seen !== 1'b1) $display("FAIL hold_done_timeout: got done=0, want 1");
    else n_pass++;
    tick();
  endtask

  task automatic test_start_hold();
    logic seen;
    bus.hold = 1'b1;
    pulse_start(5'd4, 1'b0);
    tick();
    n_total++;
    if (bus.valid !== 1'b0 || bus.busy !== 1'b1) begin
      $display("FAIL start_hold_wait: got v=%b b=%b, want v=0 b=1", bus.valid, bus.busy);
    end else n_pass++;
    bus.hold = 1'b0;
    tick();
    n_total++;
    if (bus.valid !== 1'b1 || bus.pc !== 4'd0 || op !== 3'b001) begin
      $display("FAIL start_hold_first: got v=%b pc=%0d op=%b, want v=1 pc=0 op=001", bus.valid, bus.pc, op);
    end else n_pass++;
    pulse_start(5'd4, 1'b0);
    n_total++;
    if (bus.pc !== 4'd1 || op !== 3'b010) begin
      $display("FAIL start_while_busy: got pc=%0d op=%b, want pc=1 op=010", bus.pc, op);
    end else n_pass++;
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      tick();
      if (bus.done) seen = 1'b1;
    end
    n_total++;
    if (seen !== 1'b1) $display("FAIL start_hold_done_timeout: got done=0, want 1");
    else n_pass++;
    tick();
  endtask

  task automatic test_len_bounds();
    int cnt;
    logic seen;
    logic [3:0] last_pc;
    logic [2:0] last_op;
    pulse_start(5'd0, 1'b0);
    n_total++;
    if (bus.done !== 1'b1 || bus.valid !== 1'b0) begin
      $display("FAIL len0_done: got done=%b valid=%b, want done=1 valid=0", bus.done, bus.valid);
    end else n_pass++;
    tick();
    n_total++;
    if (bus.done !== 1'b0 || bus.valid !== 1'b0 || bus.busy !== 1'b0) begin
      $display("FAIL len0_after: got d=%b v=%b b=%b, want 0 0 0", bus.done, bus.valid, bus.busy);
    end else n_pass++;
    for (int i = 4; i < 16; i++) load(4'(i), 3'(i));
    pulse_start(5'd20, 1'b0);
    cnt = 0; seen = 1'b0; last_pc = '0; last_op = '0;
    for (int i = 0; i < 30 && !seen; i++) begin
      if (bus.valid) begin
        cnt++; last_pc = bus.pc; last_op = op;
      end
      if (bus.done) seen = 1'b1;
      else tick();
    end
    n_total++;
    if (seen !== 1'b1 || cnt != 16 || last_pc !== 4'd15 || last_op !== 3'b111) begin
      $display("FAIL len20_clamp: got done=%b count=%0d last_pc=%0d last_op=%b, want 1 16 15 111",
               seen, cnt, last_pc, last_op);
    end else n_pass++;
    tick();
  endtask

  task automatic test_write_busy();
    logic seen;
    pulse_start(5'd4, 1'b0);
    bus.wr_en = 1'b1; bus.wr_addr = 4'd2; bus.wr_data = 3'b000;
    tick();
    bus.wr_en = 1'b0;
    n_total++;
    if (bus.wr_err !== 1'b1) $display("FAIL wr_err_pulse: got wr_err=%b, want 1", bus.wr_err);
    else n_pass++;
    tick();
    n_total++;
    if (bus.wr_err !== 1'b0 || op !== 3'b100 || bus.pc !== 4'd2) begin
      $display("FAIL wr_dropped: got wr_err=%b op=%b pc=%0d, want 0 100 2", bus.wr_err, op, bus.pc);
    end else n_pass++;
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      tick();
      if (bus.done) seen = 1'b1;
    end
    tick();
    load(4'd2, 3'b000);
    n_total++;
    if (seen !== 1'b1 || bus.wr_err !== 1'b0) begin
      $display("FAIL idle_write: got done_seen=%b wr_err=%b, want 1 0", seen, bus.wr_err);
    end else n_pass++;
    pulse_start(5'd4, 1'b0);
    tick(); tick();
    n_total++;
    if (op !== 3'b000 || bus.pc !== 4'd2) begin
      $display("FAIL idle_write_took: got op=%b pc=%0d, want 000 2", op, bus.pc);
    end else n_pass++;
    for (int i = 0; i < 4; i++) tick();
    load(4'd2, 3'b100);
  endtask

  task automatic test_async_reset();
    logic seen;
    pulse_start(5'd4, 1'b0);
    tick(); tick();
    #2;
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({op, bus.pc, bus.busy, bus.valid, bus.done} !== 10'b0) begin
      $display("FAIL async_reset: got op=%b pc=%0d b=%b v=%b d=%b, want all 0",
               op, bus.pc, bus.busy, bus.valid, bus.done);
    end else n_pass++;
    tick();
    rst_n = 1'b1;
    tick();
    n_total++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      $display("FAIL reset_no_done: got d=%b b=%b, want 0 0", bus.done, bus.busy);
    end else n_pass++;
    pulse_start(5'd4, 1'b0);
    n_total++;
    if (bus.valid !== 1'b1 || bus.pc !== 4'd0 || op !== 3'b001) begin
      $display("FAIL replay_after_reset: got v=%b pc=%0d op=%b, want 1 0 001", bus.valid, bus.pc, op);
    end else n_pass++;
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      tick();
      if (bus.done) seen = 1'b1;
    end
    n_total++;
    if (seen !== 1'b1) $display("FAIL replay_done_timeout: got done=0, want 1");
    else n_pass++;
    tick();
  endtask

  initial begin
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.len = '0; bus.loop_en = 1'b0; bus.start = 1'b0; bus.hold = 1'b0;
    test_reset();
    test_load_play();
    test_loop_wrap();
    test_hold();
    test_start_hold();
    test_len_bounds();
    test_write_busy();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
